// File: rtl/ram_reader.sv
// ram_reader: walks RAM 0..LAST_ADDR and hands each byte to the transmitter as two nibbles.
// Define RAM_READER_LOFIRST_EN to issue the low nibble first (default: high nibble first).
module ram_reader #(
  parameter int ADDR_W    = 5,
  parameter int LAST_ADDR = 31,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] radd,
  output logic              re,
  input  logic [7:0]        rdata,
  input  logic              nib_req,
  output logic [3:0]        nib,
  output logic              nib_valid,
  output logic              busy,
  output logic              done
);
  typedef enum logic [2:0] {IDLE, ADDR, WAIT, CAPT, HI, LO, NEXT} state_t;
  state_t      state;
  logic [7:0]  data_q;
  logic        cnt;
  logic [3:0]  nib_first, nib_second;
`ifdef RAM_READER_LOFIRST_EN
  assign nib_first  = data_q[3:0];
  assign nib_second = data_q[7:4];
`else
  assign nib_first  = data_q[7:4];
  assign nib_second = data_q[3:0];
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      radd      <= '0;
      re        <= 1'b0;
      nib       <= 4'h0;
      nib_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      data_q    <= 8'h00;
      cnt       <= 1'b0;
    end else begin
      re        <= 1'b0;
      nib_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= ADDR;
          radd  <= '0;
          re    <= 1'b1;
          busy  <= 1'b1;
        end
        ADDR: begin
          state <= WAIT;
          cnt   <= 1'(RD_LAT - 1);
        end
        WAIT: if (cnt == 1'b0) state <= CAPT; else cnt <= cnt - 1'b1;
        CAPT: begin
          data_q <= rdata;
          state  <= HI;
        end
        HI: if (nib_req) begin
          nib       <= nib_first;
          nib_valid <= 1'b1;
          state     <= LO;
        end
        LO: if (nib_req) begin
          nib       <= nib_second;
          nib_valid <= 1'b1;
          state     <= NEXT;
        end
        NEXT: if (radd == ADDR_W'(LAST_ADDR)) begin
          done  <= 1'b1;
          radd  <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end else begin
          radd  <= radd + 1'b1;
          re    <= 1'b1;
          state <= ADDR;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_reader.sv
// tb_ram_reader: random-RAM reader bench; expected nibble stream derived from RAM contents.
module tb_ram_reader;
  localparam int RD_LAT = 1;
  localparam int LAST   = 31;
`ifdef RAM_READER_LOFIRST_EN
  localparam bit LO_FIRST = 1'b1;
`else
  localparam bit LO_FIRST = 1'b0;
`endif
  logic       clk = 1'b0, reset = 1'b1, start = 1'b0, nib_req = 1'b0;
  logic [4:0] radd;
  logic       re, nib_valid, busy, done;
  logic [7:0] rdata, r1, r2;
  logic [3:0] nib;
  logic [7:0] mem [32];
  int checks = 0, errors = 0, cyc = 0;
  int nib_cnt, done_cnt, last_nib_cyc, done_cyc;
  int re_cyc[$], re_addr[$], got[$], expq[$];

  ram_reader #(.ADDR_W(5), .LAST_ADDR(LAST), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .radd(radd), .re(re), .rdata(rdata),
    .nib_req(nib_req), .nib(nib), .nib_valid(nib_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (re) r1 <= mem[radd];
    r2 <= r1;
  end
  assign rdata = (RD_LAT == 1) ? r1 : r2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (re) begin
      re_cyc.push_back(cyc);
      re_addr.push_back(int'(radd));
    end
    if (nib_valid) begin
      nib_cnt++;
      last_nib_cyc = cyc;
      got.push_back(int'(nib));
      chk("nib_valid_with_done", done, 1'b0);
      chk("nib_unexpected", expq.size() > 0, 1'b1);
      if (expq.size() > 0) chk("nib_value", nib, expq.pop_front());
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic begin_pass();
    expq.delete(); got.delete(); re_cyc.delete(); re_addr.delete();
    nib_cnt = 0; done_cnt = 0;
    for (int a = 0; a <= LAST; a++) begin
      expq.push_back(LO_FIRST ? int'(mem[a][3:0]) : int'(mem[a][7:4]));
      expq.push_back(LO_FIRST ? int'(mem[a][7:4]) : int'(mem[a][3:0]));
    end
  endtask

  task automatic finish_pass(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 2000) begin
      step();
      n++;
    end
    chk({tag, "_done_seen"}, done_cnt > 0, 1'b1);
    repeat (3) step();
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_nib_count"}, nib_cnt, 64);
    chk({tag, "_done_after_last"}, done_cyc, last_nib_cyc + 1);
    chk({tag, "_busy_after"}, busy, 1'b0);
    chk({tag, "_radd_after"}, radd, 5'd0);
    chk({tag, "_re_count"}, re_addr.size(), LAST + 1);
    for (int i = 0; i < re_addr.size(); i++) chk({tag, "_re_addr"}, re_addr[i], i);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    repeat (2) step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_radd", radd, 5'd0);
    chk("rst_re", re, 1'b0);
    chk("rst_nib", nib, 4'h0);
    chk("rst_nib_valid", nib_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    reset = 1'b0;
    nib_req = 1'b1;
    repeat (5) begin
      step();
      chk("idle_busy", busy, 1'b0);
      chk("idle_nib_valid", nib_valid, 1'b0);
      chk("idle_re", re, 1'b0);
      chk("idle_radd", radd, 5'd0);
    end

    mem[0] = 8'hA5;
    mem[1] = 8'h3C;
    begin_pass();
    pulse_start();
    finish_pass("a5_3c");
    chk("a5_nib0", got[0], LO_FIRST ? 32'h5 : 32'hA);
    chk("a5_nib1", got[1], LO_FIRST ? 32'hA : 32'h5);
    chk("a5_nib2", got[2], LO_FIRST ? 32'hC : 32'h3);
    chk("a5_nib3", got[3], LO_FIRST ? 32'h3 : 32'hC);
    for (int i = 1; i < re_cyc.size(); i++) chk("byte_spacing", re_cyc[i] - re_cyc[i-1], 5 + RD_LAT);

    for (int i = 0; i < 32; i++) mem[i] = 8'(i);
    begin_pass();
    pulse_start();
    finish_pass("ramp");

    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    begin_pass();
    nib_req = 1'b0;
    pulse_start();
    repeat (3 + RD_LAT) step();
    repeat (10) begin
      step();
      chk("stall_nib_valid", nib_valid, 1'b0);
      chk("stall_radd", radd, 5'd0);
      chk("stall_busy", busy, 1'b1);
    end
    nib_req = 1'b1;
    step();
    nib_req = 1'b0;
    chk("stall_one_nib", nib_valid, 1'b1);
    repeat (5) begin
      step();
      chk("stall_no_more", nib_valid, 1'b0);
    end
    chk("stall_nib_cnt", nib_cnt, 1);
    nib_req = 1'b1;
    finish_pass("stall");

    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    begin_pass();
    pulse_start();
    for (int n = 0; re_addr.size() < 4 && n < 200; n++) step();
    pulse_start();
    for (int n = 0; re_addr.size() < 6 && n < 200; n++) step();
    chk("ign_start_addr4", re_addr.size() > 4 ? re_addr[4] : -1, 4);
    chk("ign_start_addr5", re_addr.size() > 5 ? re_addr[5] : -1, 5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    expq.delete();
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_radd", radd, 5'd0);
    chk("midrst_re", re, 1'b0);
    chk("midrst_nib_valid", nib_valid, 1'b0);
    repeat (20) step();
    chk("midrst_no_done", done_cnt, 0);
    chk("midrst_no_reads", re_addr.size(), 6);
    begin_pass();
    pulse_start();
    finish_pass("restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
